// File: rtl/obf_insn_seq.sv
// -----------------------------------------------------------------------------
// obf_insn_seq
//
// Obfuscation sequencer between fetch and the obfuscated instruction
// generator. A reference instruction accepted from fetch is latched and held
// stable on ig_ref_insn_o while the pseudo program counter (ig_ppc_o) steps
// through the substitution sequence. Each generator word is captured into a
// registered valid/ready output stage toward decode. Fetch is back-pressured
// until the generator flags the last word. With obfuscation disabled at accept
// time, the fetched instruction passes straight into the output register.
//
// Parameters:
//   PPC_WIDTH     width of the pseudo program counter
//   MAX_SEQ       highest legal ppc value (must be <= 2**PPC_WIDTH-1)
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   fetch_valid_i/insn_i       reference instruction from fetch
//   fetch_ready_o              sequencer accepts fetch this cycle (combinational)
//   flush_i                    aborts the current sequence, drops output word
//   obf_en_i                   obfuscation enable, sampled at fetch accept
//   ig_ref_insn_o, ig_ppc_o    registered request to the generator
//   ig_insn_i, ig_last_i,      generator response for the current request
//   ig_skip_i                  (skip: word carries an immediate, ppc += 2)
//   out_valid_o/insn_o/        registered output word toward decode with
//   first_o/last_o, out_ready_i sequence boundary flags
//   seq_err_o                  one-cycle pulse when a sequence overruns MAX_SEQ
// -----------------------------------------------------------------------------
module obf_insn_seq #(
    parameter int unsigned PPC_WIDTH = 4,
    parameter int unsigned MAX_SEQ   = 15
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 fetch_valid_i,
    input  logic [31:0]          fetch_insn_i,
    output logic                 fetch_ready_o,

    input  logic                 flush_i,
    input  logic                 obf_en_i,

    output logic [31:0]          ig_ref_insn_o,
    output logic [PPC_WIDTH-1:0] ig_ppc_o,
    input  logic [31:0]          ig_insn_i,
    input  logic                 ig_last_i,
    input  logic                 ig_skip_i,

    output logic                 out_valid_o,
    output logic [31:0]          out_insn_o,
    output logic                 out_first_o,
    output logic                 out_last_o,
    input  logic                 out_ready_i,

    output logic                 seq_err_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } state_t;

    // MAX_SEQ at the width of the next-ppc adder so the overrun compare
    // sees the carry out of the PPC_WIDTH-bit counter.
    localparam logic [PPC_WIDTH:0] MAX_SEQ_W = (PPC_WIDTH + 1)'(MAX_SEQ);
    localparam logic [PPC_WIDTH:0] STEP_ONE  = (PPC_WIDTH + 1)'(1);
    localparam logic [PPC_WIDTH:0] STEP_TWO  = (PPC_WIDTH + 1)'(2);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q;
    logic [PPC_WIDTH-1:0] ppc_q;
    logic [31:0]          ref_insn_q;
    logic                 out_valid_q;
    logic [31:0]          out_insn_q;
    logic                 out_first_q;
    logic                 out_last_q;
    logic                 seq_err_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                 free_d;      // output register can take a new word
    logic                 accept_d;    // fetch handshake this cycle
    logic [PPC_WIDTH:0]   nppc_d;      // candidate next ppc, one bit wider
    logic                 overrun_d;   // candidate next ppc exceeds MAX_SEQ
    logic                 first_d;     // current generator word is word 0

    assign free_d        = !out_valid_q || out_ready_i;
    assign fetch_ready_o = (state_q == ST_IDLE) && free_d && !flush_i;
    assign accept_d      = fetch_valid_i && fetch_ready_o;

    // The extra bit keeps a wrap of the PPC_WIDTH-bit counter visible as an
    // overrun instead of silently restarting the sequence at a low ppc.
    assign nppc_d    = {1'b0, ppc_q} + (ig_skip_i ? STEP_TWO : STEP_ONE);
    assign overrun_d = (nppc_d > MAX_SEQ_W);
    assign first_d   = (ppc_q == '0);

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ppc_q       <= '0;
            ref_insn_q  <= '0;
            out_valid_q <= 1'b0;
            out_insn_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            seq_err_q   <= 1'b0;
        end else if (flush_i) begin
            // Abort: drop the pending output word and any word fetch offers
            // in the same cycle. The reference latch keeps its old value; it
            // is only meaningful while in ST_SEQ.
            state_q     <= ST_IDLE;
            ppc_q       <= '0;
            out_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            seq_err_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        if (obf_en_i) begin
                            // Start a substitution sequence. The output stage
                            // is free here, so whatever it held has either
                            // been consumed this cycle or was never valid.
                            ref_insn_q  <= fetch_insn_i;
                            ppc_q       <= '0;
                            state_q     <= ST_SEQ;
                            out_valid_q <= 1'b0;
                        end else begin
                            // Bypass: the instruction is its own one-word
                            // sequence and goes straight to the output stage.
                            out_insn_q  <= fetch_insn_i;
                            out_first_q <= 1'b1;
                            out_last_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                        end
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                    end
                end

                ST_SEQ: begin
                    // When decode stalls, nothing moves: ppc and the
                    // reference stay put so the generator word stays stable.
                    if (free_d) begin
                        out_insn_q  <= ig_insn_i;
                        out_first_q <= first_d;
                        out_valid_q <= 1'b1;

                        if (ig_last_i) begin
                            out_last_q <= 1'b1;
                            ppc_q      <= '0;
                            state_q    <= ST_IDLE;
                        end else if (overrun_d) begin
                            // The generator failed to terminate within the
                            // legal ppc range: close the sequence here so
                            // decode still sees a well-formed boundary.
                            out_last_q <= 1'b1;
                            seq_err_q  <= 1'b1;
                            ppc_q      <= '0;
                            state_q    <= ST_IDLE;
                        end else begin
                            out_last_q <= 1'b0;
                            ppc_q      <= nppc_d[PPC_WIDTH-1:0];
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ig_ref_insn_o = ref_insn_q;
    assign ig_ppc_o      = ppc_q;
    assign out_valid_o   = out_valid_q;
    assign out_insn_o    = out_insn_q;
    assign out_first_o   = out_first_q;
    assign out_last_o    = out_last_q;
    assign seq_err_o     = seq_err_q;

endmodule

// File: tb/tb_obf_insn_seq.sv
// -----------------------------------------------------------------------------
// Testbench for obf_insn_seq: directed scenarios followed by randomized
// transactions. A generator model answers ig_* from the DUT request, and the
// expected word stream of every reference instruction is computed from the
// sequencing rules (ppc walk, skip, last, overrun) into a scoreboard queue
// that is checked at each output handshake.
// -----------------------------------------------------------------------------
module tb_obf_insn_seq;

    localparam int PW = 4;
    localparam int MS = 15;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          fetch_valid;
    logic [31:0]   fetch_insn;
    logic          fetch_ready;
    logic          flush;
    logic          obf_en;
    logic [31:0]   ig_ref;
    logic [PW-1:0] ig_ppc;
    logic [31:0]   ig_insn;
    logic          ig_last;
    logic          ig_skip;
    logic          out_valid;
    logic [31:0]   out_insn;
    logic          out_first;
    logic          out_last;
    logic          out_ready;
    logic          seq_err;

    obf_insn_seq #(
        .PPC_WIDTH(PW),
        .MAX_SEQ  (MS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_valid_i(fetch_valid),
        .fetch_insn_i (fetch_insn),
        .fetch_ready_o(fetch_ready),
        .flush_i      (flush),
        .obf_en_i     (obf_en),
        .ig_ref_insn_o(ig_ref),
        .ig_ppc_o     (ig_ppc),
        .ig_insn_i    (ig_insn),
        .ig_last_i    (ig_last),
        .ig_skip_i    (ig_skip),
        .out_valid_o  (out_valid),
        .out_insn_o   (out_insn),
        .out_first_o  (out_first),
        .out_last_o   (out_last),
        .out_ready_i  (out_ready),
        .seq_err_o    (seq_err)
    );

    // ------------------------------------------------------------------
    // Generator model: word depends on (ref, ppc); last from ppc >= gen_last;
    // skip from a per-ppc mask.
    // ------------------------------------------------------------------
    int unsigned gen_last;
    logic [15:0] gen_skip;

    function automatic logic [31:0] gen_word(input logic [31:0] r, input int p);
        return (r ^ (32'h9E3779B1 * 32'(p))) + (32'(p) << 28) + 32'h1;
    endfunction

    always_comb begin
        ig_insn = gen_word(ig_ref, int'(ig_ppc));
        ig_last = (32'(ig_ppc) >= gen_last);
        ig_skip = gen_skip[ig_ppc];
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] w;
        logic        f;
        logic        l;
    } exp_t;

    exp_t exp_q[$];
    int   exp_ppc[$];
    int   exp_len;
    int   exp_err;

    int   tests = 0;
    int   fails = 0;
    bit   last_accept;
    bit   last_free;
    bit   prev_err;
    int   err_cnt;
    int   nready_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected word stream of one reference instruction, derived from the
    // sequencing rules with plain integer arithmetic.
    task automatic build(input logic [31:0] insn, input bit obf,
                         input int unsigned last, input logic [15:0] skip);
        int p;
        int np;
        bit first;
        exp_ppc.delete();
        exp_err = 0;
        if (!obf) begin
            exp_q.push_back('{w: insn, f: 1'b1, l: 1'b1});
            exp_len = 1;
            return;
        end
        p = 0;
        first = 1'b1;
        exp_len = 0;
        for (int k = 0; k < 32; k++) begin
            exp_ppc.push_back(p);
            exp_len++;
            if (p >= int'(last)) begin
                exp_q.push_back('{w: gen_word(insn, p), f: first, l: 1'b1});
                break;
            end
            np = p + (skip[p] ? 2 : 1);
            if (np > MS) begin
                exp_q.push_back('{w: gen_word(insn, p), f: first, l: 1'b1});
                exp_err = 1;
                break;
            end
            exp_q.push_back('{w: gen_word(insn, p), f: first, l: 1'b0});
            p = np;
            first = 1'b0;
        end
    endtask

    // One clock: sample just before the edge (handshake, hold, accept), then
    // check post-edge effects 1 time unit after the edge.
    task automatic step();
        logic        pre_fr, hs, hold, pre_free, pre_ctl;
        logic [31:0] s_insn, s_ref;
        logic [PW-1:0] s_ppc;
        exp_t        e;
        #1;
        pre_fr      = fetch_ready;
        hs          = out_valid && out_ready;
        hold        = out_valid && !out_ready;
        pre_free    = !out_valid || out_ready;
        pre_ctl     = rst || flush;
        last_accept = fetch_valid && fetch_ready && !rst;
        s_insn      = out_insn;
        s_ref       = ig_ref;
        s_ppc       = ig_ppc;
        if (!pre_fr) nready_cnt++;
        if (hs) begin
            chk("word_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("word", {out_insn, out_first, out_last}, e);
            end
        end
        @(posedge clk);
        #1;
        if (hold && !pre_ctl) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_insn", out_insn, s_insn);
            chk("hold_ppc", ig_ppc, s_ppc);
            chk("hold_ref", ig_ref, s_ref);
        end
        if (seq_err) begin
            err_cnt++;
            chk("err_pulse_len", prev_err, 1'b0);
            chk("err_with_last", {out_valid, out_last}, 2'b11);
        end
        prev_err  = seq_err;
        last_free = pre_free && !pre_ctl;
    endtask

    // Present one instruction and wait (bounded) for the accept edge.
    task automatic prep(input logic [31:0] insn, input bit obf, input int unsigned last,
                        input logic [15:0] skip, output int loads);
        int guard;
        build(insn, obf, last, skip);
        gen_last    = last;
        gen_skip    = skip;
        fetch_valid = 1'b1;
        fetch_insn  = insn;
        obf_en      = obf;
        out_ready   = 1'b1;
        last_accept = 1'b0;
        guard       = 0;
        while (!last_accept && guard < 40) begin
            step();
            guard++;
        end
        chk("accept", last_accept, 1'b1);
        fetch_valid = 1'b0;
        fetch_insn  = $urandom;
        obf_en      = 1'($urandom_range(0, 1));
        if (obf) begin
            chk("start_ppc", ig_ppc, 0);
            chk("start_ref", ig_ref, insn);
            chk("start_outv", out_valid, 1'b0);
            loads = 0;
        end else begin
            chk("bypass_outv", out_valid, 1'b1);
            loads = 1;
        end
        err_cnt    = 0;
        nready_cnt = 0;
    endtask

    // rmode: 0 = decode always ready, 1 = random ready,
    //        2 = 4-cycle stall while word 0 is pending and ppc is 1.
    task automatic run_txn(input logic [31:0] insn, input bit obf, input int unsigned last,
                           input logic [15:0] skip, input int rmode);
        int loads;
        int guard;
        int stall_left;
        prep(insn, obf, last, skip, loads);
        stall_left = 4;
        guard      = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (loads == 1 && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            step();
            if (loads < exp_len && last_free) begin
                loads++;
                if (loads < exp_len) chk("ppc_step", ig_ppc, exp_ppc[loads]);
            end
            guard++;
        end
        chk("drain_done", exp_q.size(), 0);
        chk("load_count", loads, exp_len);
        chk("err_pulses", err_cnt, exp_err);
        if (rmode == 0) chk("fetch_stall_cycles", nready_cnt, obf ? exp_len : 0);
        out_ready = 1'b1;
        $display("[TB] txn insn=%08h obf=%0d words=%0d err=%0d mode=%0d",
                 insn, obf, exp_len, exp_err, rmode);
    endtask

    // ------------------------------------------------------------------
    // Directed and randomized steps
    // ------------------------------------------------------------------
    initial begin
        int loads;
        rst         = 1'b1;
        fetch_valid = 1'b0;
        fetch_insn  = '0;
        flush       = 1'b0;
        obf_en      = 1'b0;
        out_ready   = 1'b1;
        gen_last    = 0;
        gen_skip    = '0;
        prev_err    = 1'b0;
        err_cnt     = 0;
        nready_cnt  = 0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_outv", out_valid, 1'b0);
        chk("rst_insn", out_insn, 0);
        chk("rst_flags", {out_first, out_last, seq_err}, 3'b000);
        chk("rst_ppc", ig_ppc, 0);
        chk("rst_ref", ig_ref, 0);
        #1 chk("rst_fetch_ready", fetch_ready, 1'b1);

        // Bypass, three-word, skip, back-pressure, overrun
        run_txn(32'hE0642000, 1'b0, 0, 16'h0000, 0);
        run_txn($urandom, 1'b1, 2, 16'h0000, 0);
        run_txn($urandom, 1'b1, 2, 16'h0001, 0);
        run_txn($urandom, 1'b1, 3, 16'h0000, 2);
        run_txn($urandom, 1'b1, 100, 16'h0000, 0);

        // Back-to-back bypass: one accept per cycle
        for (int i = 0; i < 8; i++) begin
            fetch_valid = 1'b1;
            fetch_insn  = $urandom;
            obf_en      = 1'b0;
            out_ready   = 1'b1;
            exp_q.push_back('{w: fetch_insn, f: 1'b1, l: 1'b1});
            step();
            chk("b2b_accept", last_accept, 1'b1);
        end
        fetch_valid = 1'b0;
        step();
        chk("b2b_drained", exp_q.size(), 0);

        // Flush at ppc 1 with a word offered in the same cycle
        prep(32'hA5A50001, 1'b1, 2, 16'h0000, loads);
        out_ready = 1'b1;
        step();
        chk("flush_pre_ppc", ig_ppc, 1);
        flush       = 1'b1;
        fetch_valid = 1'b1;
        fetch_insn  = 32'h12345678;
        obf_en      = 1'b0;
        #1 chk("flush_fetch_ready", fetch_ready, 1'b0);
        step();
        chk("flush_no_accept", last_accept, 1'b0);
        chk("flush_outv", out_valid, 1'b0);
        chk("flush_ppc", ig_ppc, 0);
        exp_q.delete();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        step();
        chk("flush_word_dropped", out_valid, 1'b0);
        run_txn($urandom, 1'b1, 2, 16'h0000, 0);

        // Reset asserted mid-sequence at ppc 2
        prep(32'h5A5A0002, 1'b1, 4, 16'h0000, loads);
        step();
        step();
        chk("rst_mid_pre_ppc", ig_ppc, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_outv", out_valid, 1'b0);
        chk("rst_mid_insn", out_insn, 0);
        chk("rst_mid_flags", {out_first, out_last, seq_err}, 3'b000);
        chk("rst_mid_ppc", ig_ppc, 0);
        chk("rst_mid_ref", ig_ref, 0);
        #1 chk("rst_mid_fetch_ready", fetch_ready, 1'b1);
        exp_q.delete();
        prev_err = 1'b0;
        run_txn($urandom, 1'b1, 1, 16'h0000, 0);

        // Randomized transactions with random decode back-pressure
        for (int i = 0; i < 30; i++) begin
            run_txn($urandom,
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 5) == 0) ? 100 : $urandom_range(0, 6),
                    16'($urandom),
                    1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/obf_insn_seq.md
# obf_insn_seq

Obfuscation sequencer sitting between the fetch stage and the obfuscated instruction generator. It accepts one reference instruction at a time from fetch and holds it stable on the generator's `ref_insn` input. It steps the pseudo program counter (`ppc`) and collects the generator's output words into a registered valid/ready output toward decode. It back-pressures fetch until the generator flags the last word of the substitution sequence.

## Interface
Parameters:
- `PPC_WIDTH`, default 4 (= `OBF_PPC_WIDTH`): width of the pseudo program counter.
- `MAX_SEQ`, default 15: highest legal `ppc` value; must be at most 2^PPC_WIDTH-1.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `fetch_valid_i`  in  1: fetch presents a reference instruction.
- `fetch_insn_i`  in  32: reference instruction.
- `fetch_ready_o`  out  1: sequencer accepts `fetch_insn_i` this cycle.
- `flush_i`  in  1: branch/exception flush; aborts the current sequence.
- `obf_en_i`  in  1: obfuscation enable; sampled at fetch accept.
- `ig_ref_insn_o`  out  32: latched reference instruction, to the generator.
- `ig_ppc_o`  out  PPC_WIDTH: current `ppc`, to the generator.
- `ig_insn_i`  in  32: generator word for (`ig_ref_insn_o`, `ig_ppc_o`); combinational.
- `ig_last_i`  in  1: generator flags the current word as last in the sequence.
- `ig_skip_i`  in  1: current word carries an inline immediate; `ppc` advances by 2.
- `out_valid_o`  out  1: registered output word valid.
- `out_insn_o`  out  32: registered output word.
- `out_first_o`  out  1: word is the first of its sequence.
- `out_last_o`  out  1: word is the last of its sequence.
- `out_ready_i`  in  1: decode consumes the output word.
- `seq_err_o`  out  1: one-cycle pulse when a sequence overruns `MAX_SEQ`.

## Operation
- States: IDLE, SEQ.
- `free` = !`out_valid_o` || `out_ready_i`.
- `fetch_ready_o` = (state==IDLE) && `free` && !`flush_i`.
- **IDLE, fetch accepted (`fetch_valid_i` && `fetch_ready_o`):**
  - `obf_en_i`=1: latch `fetch_insn_i` into `ig_ref_insn_o`, set `ppc`=0, go to SEQ. The output register is not loaded this edge; if `out_ready_i` was high, `out_valid_o` clears.
  - `obf_en_i`=0 (bypass): load the output register with `fetch_insn_i`, set first=last=1 and `out_valid_o`=1, stay in IDLE.
- **SEQ, when `free`:**
  - Load the output register with `ig_insn_i`; set `out_first_o`=(`ppc`==0), `out_last_o`=`ig_last_i`, `out_valid_o`=1.
  - If `ig_last_i`: go to IDLE, `ppc`=0.
  - Else compute `nppc` = `ppc` + (`ig_skip_i` ? 2 : 1) at PPC_WIDTH+1 bits. If `nppc` > MAX_SEQ: force `out_last_o`=1, pulse `seq_err_o`, go to IDLE. Otherwise `ppc`=`nppc`.
- **SEQ, not `free`:** hold all state. `ig_*` outputs stay stable.
- **IDLE, not `free` and not accepting:** output register holds; cleared when `out_ready_i` && !load.
- **Flush** (priority below reset, above everything else): `out_valid_o`=0, state=IDLE, `ppc`=0. No fetch accept in that cycle. A word presented together with `flush_i` is dropped.
- **Reset:** state=IDLE; `ppc`=0; `ig_ref_insn_o`=0; `out_valid_o`, `out_insn_o`, `out_first_o`, `out_last_o`, `seq_err_o` all 0. Because `fetch_ready_o` is combinational, it reads 1 from the first cycle after reset.

## Timing
- Accept at edge N with obfuscation: word 0 is valid after edge N+1. With `out_ready_i` held high, word k is valid after edge N+1+k.
- Bypass: word valid after edge N. Back-to-back bypass sustains 1 instruction/cycle.
- Next fetch accept is possible in the cycle after the edge that loads the last word. So an obfuscated sequence of L words costs L+1 cycles per reference instruction.
- `seq_err_o` is high for exactly the cycle after the offending edge.
- `ig_ppc_o` and `ig_ref_insn_o` are registered and change only on load edges, flush, or reset.

## Test plan
- Reset, then bypass: `obf_en_i`=0, fetch `32'hE0642000` with `out_ready_i`=1. Require `out_valid_o`=1 one edge later, `out_insn_o`=`32'hE0642000`, first=last=1; `fetch_ready_o` stays 1.
- Three-word sequence: the generator model returns W0,W1,W2 for ppc 0,1,2, with last at ppc 2. Require outputs on consecutive cycles, `ig_ppc_o` 0→1→2, first only on W0, last only on W2, and `fetch_ready_o`=0 for exactly 3 cycles.
- Skip: the model asserts `ig_skip_i` at ppc 0. Require `ig_ppc_o` sequence 0→2, with the last word at ppc 2.
- Back-pressure: hold `out_ready_i`=0 for 4 cycles mid-sequence at ppc 1. Require `out_insn_o`, `ig_ppc_o` and `out_valid_o` stable, and no word lost or duplicated on release.
- Overrun: the model never asserts last, `MAX_SEQ`=15. Require 16 words, the 16th with last=1, a single-cycle `seq_err_o` pulse, and return to IDLE.
- Flush mid-sequence at ppc 1 with `fetch_valid_i`=1: require `out_valid_o`=0 next cycle, no accept during the flush cycle, and the next accept restarting at `ig_ppc_o`=0. Repeat with `rst` asserted mid-sequence and require all reset values.
